hept_stage_sequencer: RTL and testbench

HEPT_STAGE_SEQUENCER -- requirements
Module: hept_stage_sequencer

---
 rtl/hept_ctrl_pkg.sv | 22 ++
 rtl/hept_stage_starter.sv | 51 +++++
 rtl/hept_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_hept_stage_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hept_ctrl_pkg.sv
// Shared types and constants for the hept stage sequencer.
package hept_ctrl_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;
   localparam int unsigned LAT_W_DEFAULT          = 32;
   localparam int unsigned STG_W                  = 2;

   // Stage indices reported on err_stage
   localparam logic [STG_W-1:0] STG_T = 2'd0;
   localparam logic [STG_W-1:0] STG_D = 2'd1;
   localparam logic [STG_W-1:0] STG_M = 2'd2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN_T = 3'd1,
      RUN_D = 3'd2,
      RUN_M = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage

// File: rtl/hept_stage_starter.sv
// Per-unit start handshake: raise start on stage entry, hold until ready is
// seen, and remember a done pulse for the rest of the stage.
module hept_stage_starter (
   input  logic clk_i,
   input  logic rst_i,
   input  logic arm_i,       // stage is entered on the next edge
   input  logic hold_i,      // stage is still current after the next edge
   input  logic active_i,    // stage is current this cycle
   input  logic ready_i,
   input  logic done_i,
   output logic start_o,
   output logic done_seen_o
);

   logic start_q, start_d;
   logic seen_q, seen_d;

   // Next-state for the start request and the sticky done flag
   always_comb begin
      start_d = start_q;
      seen_d  = seen_q;
      if (arm_i) begin
         start_d = 1'b1;
         seen_d  = 1'b0;
      end else begin
         if (!hold_i) begin
            start_d = 1'b0;
         end else if (start_q && ready_i) begin
            start_d = 1'b0;
         end
         if (active_i && done_i) begin
            seen_d = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         start_q <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         start_q <= start_d;
         seen_q  <= seen_d;
      end
   end

   assign start_o     = start_q;
   assign done_seen_o = seen_q;

endmodule

// File: rtl/hept_stage_sequencer.sv
// Sequences transpose (x2) -> distance -> mask stages behind an ap_ctrl_hs
// handshake, with a per-stage watchdog and a run-latency counter.
module hept_stage_sequencer
   import hept_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned LAT_W          = LAT_W_DEFAULT
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_ready,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             t0_start,
   input  logic             t0_ready,
   input  logic             t0_done,
   output logic             t1_start,
   input  logic             t1_ready,
   input  logic             t1_done,
   output logic             d_start,
   input  logic             d_ready,
   input  logic             d_done,
   output logic             m_start,
   input  logic             m_ready,
   input  logic             m_done,
   output logic             err,
   output logic [1:0]       err_stage,
   output logic [LAT_W-1:0] last_latency
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state_q, state_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [LAT_W-1:0]   lat_q, lat_d, lat_p1, lat_p2;
   logic [LAT_W-1:0]   last_lat_q, last_lat_d;
   logic               err_q, err_d;
   logic [STG_W-1:0]   err_stage_q, err_stage_d;
   logic               ap_idle_q, ap_done_q;

   logic in_t_c, in_d_c, in_m_c;
   logic nx_t_c, nx_d_c, nx_m_c;
   logic t0_seen, t1_seen, d_seen, m_seen;
   logic t_exit_c, d_exit_c, m_exit_c, wd_expired_c;

   assign in_t_c = (state_q == RUN_T);
   assign in_d_c = (state_q == RUN_D);
   assign in_m_c = (state_q == RUN_M);
   assign nx_t_c = (state_d == RUN_T);
   assign nx_d_c = (state_d == RUN_D);
   assign nx_m_c = (state_d == RUN_M);

   hept_stage_starter u_t0 (
      .clk_i(ap_clk), .rst_i(ap_rst), .arm_i(nx_t_c && !in_t_c), .hold_i(nx_t_c),
      .active_i(in_t_c), .ready_i(t0_ready), .done_i(t0_done),
      .start_o(t0_start), .done_seen_o(t0_seen)
   );

   hept_stage_starter u_t1 (
      .clk_i(ap_clk), .rst_i(ap_rst), .arm_i(nx_t_c && !in_t_c), .hold_i(nx_t_c),
      .active_i(in_t_c), .ready_i(t1_ready), .done_i(t1_done),
      .start_o(t1_start), .done_seen_o(t1_seen)
   );

   hept_stage_starter u_d (
      .clk_i(ap_clk), .rst_i(ap_rst), .arm_i(nx_d_c && !in_d_c), .hold_i(nx_d_c),
      .active_i(in_d_c), .ready_i(d_ready), .done_i(d_done),
      .start_o(d_start), .done_seen_o(d_seen)
   );

   hept_stage_starter u_m (
      .clk_i(ap_clk), .rst_i(ap_rst), .arm_i(nx_m_c && !in_m_c), .hold_i(nx_m_c),
      .active_i(in_m_c), .ready_i(m_ready), .done_i(m_done),
      .start_o(m_start), .done_seen_o(m_seen)
   );

   // Stage exits combine the sticky flag with this cycle's done input
   assign t_exit_c     = (t0_seen || t0_done) && (t1_seen || t1_done);
   assign d_exit_c     = d_seen || d_done;
   assign m_exit_c     = m_seen || m_done;
   assign wd_expired_c = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Next-state and error capture; a stage exit beats a same-cycle timeout
   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      err_stage_d = err_stage_q;
      case (state_q)
         IDLE: begin
            if (ap_start) state_d = RUN_T;
         end
         RUN_T: begin
            if (t_exit_c) begin
               state_d = RUN_D;
            end else if (wd_expired_c) begin
               state_d     = ERR;
               err_stage_d = STG_T;
            end
         end
         RUN_D: begin
            if (d_exit_c) begin
               state_d = RUN_M;
            end else if (wd_expired_c) begin
               state_d     = ERR;
               err_stage_d = STG_D;
            end
         end
         RUN_M: begin
            if (m_exit_c) begin
               state_d = DONE;
            end else if (wd_expired_c) begin
               state_d     = ERR;
               err_stage_d = STG_M;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
      if (state_d == ERR) err_d = 1'b1;
   end

   // Watchdog and latency counters
   always_comb begin
      wd_d       = wd_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
      lat_p1     = (&lat_q)  ? lat_q  : lat_q  + LAT_W'(1);
      lat_p2     = (&lat_p1) ? lat_p1 : lat_p1 + LAT_W'(1);

      if (state_d != state_q) begin
         wd_d = '0;
      end else if (in_t_c || in_d_c || in_m_c) begin
         wd_d = wd_q + WD_W'(1);
      end

      if (state_q == IDLE) begin
         if (state_d == RUN_T) lat_d = '0;
      end else begin
         lat_d = lat_p1;
      end

      // Published during DONE: counts the current cycle and the DONE cycle
      if ((state_d == DONE) && (state_q != DONE)) begin
         last_lat_d = lat_p2;
      end
   end

   // State and output registers
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= IDLE;
         wd_q        <= '0;
         lat_q       <= '0;
         last_lat_q  <= '0;
         err_q       <= 1'b0;
         err_stage_q <= STG_T;
         ap_idle_q   <= 1'b1;
         ap_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wd_q        <= wd_d;
         lat_q       <= lat_d;
         last_lat_q  <= last_lat_d;
         err_q       <= err_d;
         err_stage_q <= err_stage_d;
         ap_idle_q   <= (state_d == IDLE);
         ap_done_q   <= (state_d == DONE);
      end
   end

   assign ap_idle      = ap_idle_q;
   assign ap_done      = ap_done_q;
   assign ap_ready     = ap_done_q;
   assign err          = err_q;
   assign err_stage    = err_stage_q;
   assign last_latency = last_lat_q;

endmodule

// File: tb/tb_hept_stage_sequencer.sv
// Directed bench for hept_stage_sequencer with simple behavioural stage units.
module tb_hept_stage_sequencer;

   localparam int unsigned TO = 16;
   localparam int unsigned LW = 32;

   logic          ap_clk = 1'b0;
   logic          ap_rst = 1'b1;
   logic          ap_start = 1'b0;
   logic          ap_ready, ap_done, ap_idle;
   logic          t0_start, t1_start, d_start, m_start;
   logic          t0_ready = 1'b0, t1_ready = 1'b0, d_ready = 1'b0, m_ready = 1'b0;
   logic          t0_done = 1'b0, t1_done = 1'b0, d_done = 1'b0, m_done = 1'b0;
   logic          err;
   logic [1:0]    err_stage;
   logic [LW-1:0] last_latency;

   hept_stage_sequencer #(.TIMEOUT_CYCLES(TO), .LAT_W(LW)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
      .t0_start(t0_start), .t0_ready(t0_ready), .t0_done(t0_done),
      .t1_start(t1_start), .t1_ready(t1_ready), .t1_done(t1_done),
      .d_start(d_start), .d_ready(d_ready), .d_done(d_done),
      .m_start(m_start), .m_ready(m_ready), .m_done(m_done),
      .err(err), .err_stage(err_stage), .last_latency(last_latency)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_pass = 0;

   // Unit models: index 0=t0, 1=t1, 2=d, 3=m; delays counted from first start cycle
   int rdy_dly [4];
   int dn_dly  [4];
   bit act     [4];
   int kk      [4];

   // Run monitors
   int run_cyc, d_first, d_hi, d_acc, t0_hi, done_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic set_unit(input int u, input int r, input int d);
      rdy_dly[u] = r;
      dn_dly[u]  = d;
   endtask

   task automatic clear_units();
      for (int u = 0; u < 4; u++) begin
         act[u] = 1'b0;
         kk[u]  = 0;
         set_unit(u, 0, 3);
      end
      {m_ready, d_ready, t1_ready, t0_ready} = 4'b0;
      {m_done, d_done, t1_done, t0_done}     = 4'b0;
   endtask

   // One clock: sample outputs 1ns after the edge, then drive unit responses
   task automatic step();
      logic [3:0] st;
      logic [3:0] rv;
      logic [3:0] dv;
      @(posedge ap_clk);
      #1;
      run_cyc++;
      st = {m_start, d_start, t1_start, t0_start};
      for (int u = 0; u < 4; u++) begin
         rv[u] = 1'b0;
         dv[u] = 1'b0;
         if (!act[u] && (st[u] === 1'b1)) begin
            act[u] = 1'b1;
            kk[u]  = 0;
         end else if (act[u]) begin
            kk[u]++;
         end
         if (act[u]) begin
            if (kk[u] == rdy_dly[u]) rv[u] = 1'b1;
            if (kk[u] == dn_dly[u]) begin
               dv[u]  = 1'b1;
               act[u] = 1'b0;
            end
         end
      end
      {m_ready, d_ready, t1_ready, t0_ready} = rv;
      {m_done, d_done, t1_done, t0_done}     = dv;
      if (ap_done === 1'b1) done_cnt++;
      if (d_start === 1'b1) begin
         d_hi++;
         if (d_first < 0) d_first = run_cyc;
      end
      if ((d_start === 1'b1) && d_ready) d_acc++;
      if (t0_start === 1'b1) t0_hi++;
   endtask

   // Pulse ap_start from IDLE; returns in RUN_T cycle 0
   task automatic start_run();
      run_cyc  = -1;
      d_first  = -1;
      d_hi     = 0;
      d_acc    = 0;
      t0_hi    = 0;
      done_cnt = 0;
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int n);
      n = 0;
      while ((ap_done !== 1'b1) && (n < maxc)) begin
         step();
         n++;
      end
   endtask

   task automatic wait_err(input int maxc, output int n);
      n = 0;
      while ((err !== 1'b1) && (n < maxc)) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int first_done, second_done;
      logic idle_gap;

      clear_units();
      run_cyc = 0; d_first = -1; d_hi = 0; d_acc = 0; t0_hi = 0; done_cnt = 0;

      // Reset state
      ap_rst = 1'b1;
      repeat (2) step();
      chk("rst_idle", ap_idle, 1);
      chk("rst_done", {ap_done, ap_ready}, 0);
      chk("rst_starts", {t0_start, t1_start, d_start, m_start}, 0);
      chk("rst_err", {err, err_stage}, 0);
      chk("rst_lat", last_latency, 0);
      ap_rst = 1'b0;
      step();

      // Nominal run: ready with start, done 3 cycles later
      start_run();
      chk("nom_tstart_c0", {t0_start, t1_start}, 2'b11);
      chk("nom_idle_low", ap_idle, 0);
      wait_done(40, n);
      chk("nom_done_cycle", n, 12);
      chk("nom_ready", ap_ready, 1);
      chk("nom_latency", last_latency, 13);
      chk("nom_d_accept", d_acc, 1);
      step();
      chk("nom_done_1cyc", ap_done, 0);
      chk("nom_back_idle", ap_idle, 1);

      // Staggered transpose completions
      set_unit(0, 0, 2);
      set_unit(1, 0, 9);
      start_run();
      wait_done(60, n);
      chk("stag_d_first", d_first, 10);
      chk("stag_t0_hi", t0_hi, 1);
      chk("stag_done_cycle", n, 18);
      chk("stag_latency", last_latency, 19);
      step();
      clear_units();

      // Delayed d_ready
      set_unit(2, 5, 7);
      start_run();
      wait_done(60, n);
      chk("dly_d_first", d_first, 4);
      chk("dly_d_hi", d_hi, 6);
      chk("dly_d_accept", d_acc, 1);
      chk("dly_latency", last_latency, 17);
      step();
      clear_units();

      // Reset in RUN_D; the d unit's late done lands in IDLE and is ignored
      start_run();
      repeat (4) step();
      chk("rstd_d_high", d_start, 1);
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      chk("rstd_idle", ap_idle, 1);
      chk("rstd_d_low", d_start, 0);
      chk("rstd_no_done", ap_done, 0);
      chk("rstd_lat_clr", last_latency, 0);
      repeat (5) step();
      chk("rstd_no_pulse", done_cnt, 0);
      chk("rstd_still_idle", ap_idle, 1);
      clear_units();
      start_run();
      wait_done(40, n);
      chk("rstd_rerun_cycle", n, 12);
      chk("rstd_rerun_lat", last_latency, 13);
      step();

      // ap_start held across two runs
      run_cyc = -1; done_cnt = 0;
      first_done = -1; second_done = -1; idle_gap = 1'b0;
      ap_start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (run_cyc == 13) idle_gap = ap_idle;
         if (ap_done === 1'b1) begin
            if (first_done < 0) first_done = run_cyc;
            else begin
               second_done = run_cyc;
               break;
            end
         end
      end
      ap_start = 1'b0;
      chk("b2b_first", first_done, 12);
      chk("b2b_gap", second_done - first_done, 14);
      chk("b2b_idle_between", idle_gap, 1);
      step();
      step();
      chk("b2b_stop_idle", ap_idle, 1);

      // m_done on the last watchdog cycle wins over the timeout
      set_unit(3, 0, 15);
      start_run();
      wait_done(60, n);
      chk("race_done_cycle", n, 24);
      chk("race_latency", last_latency, 25);
      chk("race_no_err", err, 0);
      step();
      clear_units();

      // Distance stage never ready nor done
      set_unit(2, 1000, 1000);
      start_run();
      wait_err(60, n);
      chk("dto_err_cycle", n, 20);
      chk("dto_err_stage", err_stage, 1);
      chk("dto_d_low", d_start, 0);
      chk("dto_not_idle", ap_idle, 0);
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      clear_units();

      // Mask stage never done
      set_unit(3, 0, 1000);
      start_run();
      wait_err(60, n);
      chk("mto_err_cycle", n, 24);
      chk("mto_err_stage", err_stage, 2);
      chk("mto_quiet", {m_start, ap_done, ap_idle}, 0);
      ap_start = 1'b1;
      repeat (5) step();
      chk("mto_sticky", {err, t0_start, ap_idle}, 3'b100);
      ap_start = 1'b0;
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      clear_units();
      chk("mto_rst_err", {err, err_stage}, 0);
      chk("mto_rst_idle", ap_idle, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
